// File: rtl/ram_pkg.sv
// -----------------------------------------------------------------------------
// ram_pkg
// Shared types and default geometry for the single-port RAM access controller
// and its read-response pipe.
//   AW / DW / DEPTH     : default address width, data width and fill length
//   ram_ctrl_state_t    : controller state (IDLE serving requests, INIT filling)
//   ram_addr_t / ram_word_t : address and data word types at default geometry
// -----------------------------------------------------------------------------
package ram_pkg;

   localparam int AW    = 8;
   localparam int DW    = 16;
   localparam int DEPTH = 2**AW;

   typedef enum logic {IDLE, INIT} ram_ctrl_state_t;

   typedef logic [AW-1:0] ram_addr_t;
   typedef logic [DW-1:0] ram_word_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// -----------------------------------------------------------------------------
// ram_rd_pipe
// Tracks reads in flight to the RAM and captures their data when it arrives.
// A read tag enters on the acceptance edge and walks RD_LAT+1 stages; when it
// leaves, the RAM output is registered into rsp_data and rsp_valid pulses for
// one cycle. No back-pressure: a response is always taken.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears tags and data)
//   push           a read was accepted on this edge
//   ram_data_out   data from the RAM
//   rsp_valid      one-cycle response strobe
//   rsp_data       read result, held between responses
// -----------------------------------------------------------------------------
module ram_rd_pipe
   import ram_pkg::*;
#(
   parameter int DW     = ram_pkg::DW,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] ram_data_out,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data
);

   // vld_p[0] is loaded on the acceptance edge; the RAM needs one edge to
   // sample the request plus RD_LAT edges to produce data, so the tag in
   // vld_p[RD_LAT] lines up with valid RAM output.
   logic [RD_LAT:0] vld_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         vld_p[0] <= push;
         for (int i = 1; i <= RD_LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
         // ---- response stage ----
         rsp_valid <= vld_p[RD_LAT];
         if (vld_p[RD_LAT]) begin
            rsp_data <= ram_data_out;
         end
      end
   end

endmodule

// File: rtl/ram_port_ctrl.sv
// -----------------------------------------------------------------------------
// ram_port_ctrl
// Sole owner of the RAM control pins. Serves read/write requests over a
// valid/ready handshake (one per cycle, no bubbles) and runs a fill sequencer
// that writes a constant to every word on request.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   init_start, init_value     one-cycle fill request and its fill word
//   init_busy                  high while the fill runs (DEPTH cycles)
//   req_valid/req_ready        request handshake (req_ready is combinational)
//   req_write/req_addr/req_wdata  request contents (1 = write)
//   rsp_valid/rsp_data         read response, RD_LAT+1 edges after acceptance
//   ram_addr/ram_data_in/ram_enable/ram_write_en  registered RAM pins
//   ram_data_out               RAM read data
// -----------------------------------------------------------------------------
module ram_port_ctrl
   import ram_pkg::*;
#(
   parameter int AW     = ram_pkg::AW,
   parameter int DW     = ram_pkg::DW,
   parameter int DEPTH  = 2**AW,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          init_start,
   input  logic [DW-1:0] init_value,
   output logic          init_busy,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data_in,
   output logic          ram_enable,
   output logic          ram_write_en,
   input  logic [DW-1:0] ram_data_out
);

   ram_ctrl_state_t state;
   logic [AW-1:0]   fill_cnt;   // next fill address to issue
   logic            fill_last;  // last fill write already on the pins
   logic [DW-1:0]   fill_val;
   logic            accept;

   // A fill request takes priority over a request arriving in the same cycle.
   // Gating with rst_n keeps every output low while reset is asserted.
   assign req_ready = rst_n && (state == IDLE) && !init_start;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         fill_cnt     <= '0;
         fill_last    <= 1'b0;
         fill_val     <= '0;
         init_busy    <= 1'b0;
         ram_addr     <= '0;
         ram_data_in  <= '0;
         ram_enable   <= 1'b0;
         ram_write_en <= 1'b0;
      end else begin
         ram_enable   <= 1'b0;
         ram_write_en <= 1'b0;
         case (state)
            IDLE: begin
               if (init_start) begin
                  // Address 0 goes out on the start edge itself.
                  state        <= INIT;
                  init_busy    <= 1'b1;
                  fill_val     <= init_value;
                  ram_enable   <= 1'b1;
                  ram_write_en <= 1'b1;
                  ram_addr     <= '0;
                  ram_data_in  <= init_value;
                  fill_cnt     <= (DEPTH == 1) ? '0 : AW'(1);
                  fill_last    <= (DEPTH == 1);
               end else if (accept) begin
                  ram_enable   <= 1'b1;
                  ram_write_en <= req_write;
                  ram_addr     <= req_addr;
                  ram_data_in  <= req_wdata;
               end
            end
            INIT: begin
               if (fill_last) begin
                  // One idle cycle after the final write: busy drops and
                  // req_ready returns on the following cycle.
                  state     <= IDLE;
                  init_busy <= 1'b0;
                  fill_last <= 1'b0;
               end else begin
                  ram_enable   <= 1'b1;
                  ram_write_en <= 1'b1;
                  ram_addr     <= fill_cnt;
                  ram_data_in  <= fill_val;
                  fill_last    <= (fill_cnt == AW'(DEPTH-1));
                  fill_cnt     <= (fill_cnt == AW'(DEPTH-1)) ? '0 : fill_cnt + AW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   ram_rd_pipe #(
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (accept && !req_write),
      .ram_data_out (ram_data_out),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data)
   );

endmodule

// File: tb/tb_ram_port_ctrl.sv
module tb_ram_port_ctrl;

   localparam int AW     = 8;
   localparam int DW     = 16;
   localparam int DEPTH  = 256;
   localparam int RD_LAT = 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          init_start;
   logic [DW-1:0] init_value;
   logic          init_busy;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data_in;
   logic          ram_enable;
   logic          ram_write_en;
   logic [DW-1:0] ram_data_out;

   always #5 clk = ~clk;

   ram_port_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .init_start   (init_start),
      .init_value   (init_value),
      .init_busy    (init_busy),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_enable   (ram_enable),
      .ram_write_en (ram_write_en),
      .ram_data_out (ram_data_out)
   );

   // Behavioural 256x16 RAM with one edge of read latency.
   logic [DW-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (ram_enable) begin
         if (ram_write_en) ram_mem[ram_addr] <= ram_data_in;
         else              ram_data_out      <= ram_mem[ram_addr];
      end
   end

   // ---- reference model state ----
   typedef struct {
      int            t;
      logic [DW-1:0] d;
   } rsp_t;

   logic [DW-1:0] exp_mem [DEPTH];
   rsp_t          q[$];
   int            fill_rem = 0;   // busy cycles left in the current fill
   int            fill_k   = 0;   // index of the most recent fill write
   logic [DW-1:0] fill_val;
   int            cyc      = 0;
   int            checks   = 0;
   int            failures = 0;
   int            rsp_count = 0;
   logic          last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic zero_check(input string tag);
      chk({tag, ".ram_enable"},   ram_enable,   0);
      chk({tag, ".ram_write_en"}, ram_write_en, 0);
      chk({tag, ".ram_addr"},     ram_addr,     0);
      chk({tag, ".ram_data_in"},  ram_data_in,  0);
      chk({tag, ".init_busy"},    init_busy,    0);
      chk({tag, ".rsp_valid"},    rsp_valid,    0);
      chk({tag, ".rsp_data"},     rsp_data,     0);
   endtask

   task automatic pins_chk(input string tag, input logic en, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
      chk({tag, ".ram_enable"},   ram_enable,   en);
      chk({tag, ".ram_write_en"}, ram_write_en, we);
      if (en) begin
         chk({tag, ".ram_addr"},    ram_addr,    a);
         chk({tag, ".ram_data_in"}, ram_data_in, d);
      end
   endtask

   // One clock: check ready, let the edge happen, then compare pins, busy and
   // responses with what the model says this cycle should hold.
   task automatic step();
      logic exp_ready, start, acc;
      rsp_t r;
      #1;
      exp_ready = rst_n && (fill_rem == 0) && !init_start;
      chk("req_ready", req_ready, exp_ready);
      start    = rst_n && (fill_rem == 0) && init_start;
      acc      = req_valid && exp_ready;
      last_acc = acc;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         zero_check("in_reset");
         return;
      end
      if (start) begin
         fill_rem   = DEPTH;
         fill_k     = 0;
         fill_val   = init_value;
         exp_mem[0] = fill_val;
         pins_chk("fill", 1, 1, 0, fill_val);
      end else if (fill_rem > 0) begin
         fill_rem--;
         fill_k++;
         if (fill_k < DEPTH) begin
            exp_mem[fill_k] = fill_val;
            pins_chk("fill", 1, 1, fill_k, fill_val);
         end else begin
            pins_chk("fill_end", 0, 0, 0, 0);
         end
      end else if (acc) begin
         pins_chk("req", 1, req_write, req_addr, req_wdata);
         if (req_write) exp_mem[req_addr] = req_wdata;
         else begin
            r.t = cyc + RD_LAT + 1;
            r.d = exp_mem[req_addr];
            q.push_back(r);
         end
      end else begin
         pins_chk("idle", 0, 0, 0, 0);
      end
      chk("init_busy", init_busy, (fill_rem > 0));
      if (q.size() > 0 && q[0].t == cyc) begin
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_data", rsp_data, q[0].d);
         void'(q.pop_front());
      end else begin
         chk("rsp_valid_idle", rsp_valid, 0);
      end
      if (rsp_valid === 1'b1) rsp_count++;
   endtask

   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      step();
   endtask

   task automatic idle_steps(input int n);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_fill(input logic [DW-1:0] v);
      init_start = 1'b1;
      init_value = v;
      step();
      init_start = 1'b0;
      for (int i = 0; i < DEPTH + 4 && fill_rem > 0; i++) step();
   endtask

   initial begin
      int busy_cnt;
      int rc0;
      rst_n      = 1'b0;
      init_start = 1'b0;
      init_value = '0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;

      // Reset held for three cycles, then released.
      for (int i = 0; i < 3; i++) step();
      rst_n = 1'b1;
      #1;
      zero_check("after_release");
      chk("ready_after_release", req_ready, 1);

      // Fill with A5A5 and count busy cycles.
      init_start = 1'b1;
      init_value = 16'hA5A5;
      step();
      init_start = 1'b0;
      busy_cnt = (init_busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < DEPTH + 4 && fill_rem > 0; i++) begin
         step();
         if (init_busy === 1'b1) busy_cnt++;
      end
      chk("busy_cycles", busy_cnt, DEPTH);
      issue(0, 8'd0, '0);
      issue(0, 8'd37, '0);
      issue(0, 8'd255, '0);
      idle_steps(4);
      chk("fill_readback_drained", q.size(), 0);

      // Write i*2 then stream reads back.
      for (int i = 0; i < 150; i++) issue(1, AW'(i), DW'(i * 2));
      rc0 = rsp_count;
      for (int i = 0; i < 150; i++) issue(0, AW'(i), '0);
      idle_steps(4);
      chk("stream_rsp_count", rsp_count - rc0, 150);

      // Read-after-write on consecutive requests.
      issue(1, 8'd10, 16'h1234);
      issue(0, 8'd10, '0);
      idle_steps(4);

      // Two reads in flight, then fill request colliding with a read request.
      issue(0, 8'd3, '0);
      issue(0, 8'd140, '0);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 8'd7;
      init_start = 1'b1;
      init_value = DW'($urandom);
      step();
      chk("collide_not_accepted", last_acc, 0);
      init_start = 1'b0;
      for (int n = 0; n < DEPTH + 8 && !last_acc; n++) step();
      chk("late_req_accepted", last_acc, 1);
      idle_steps(4);
      chk("collide_drained", q.size(), 0);

      // Randomised traffic.
      for (int i = 0; i < 300; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_write = 1'($urandom_range(0, 1));
         req_addr  = AW'($urandom_range(0, DEPTH - 1));
         req_wdata = DW'($urandom);
         step();
      end
      idle_steps(4);
      chk("random_drained", q.size(), 0);

      // Reset while a read is in flight discards its response.
      issue(0, 8'd20, '0);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      zero_check("reset_mid_read");
      q.delete();
      fill_rem = 0;
      step();
      step();
      rst_n = 1'b1;
      idle_steps(4);

      // Reset during the fill at address 100, then restart the fill.
      init_start = 1'b1;
      init_value = 16'h5A3C;
      step();
      init_start = 1'b0;
      for (int i = 0; i < DEPTH && fill_k < 100; i++) step();
      chk("fill_at_100", ram_addr, 100);
      rst_n = 1'b0;
      #1;
      zero_check("reset_mid_fill");
      chk("ready_in_reset", req_ready, 0);
      q.delete();
      fill_rem = 0;
      step();
      step();
      rst_n = 1'b1;
      run_fill(16'hC3D2);
      issue(0, 8'd0, '0);
      issue(0, 8'd100, '0);
      issue(0, 8'd255, '0);
      idle_steps(4);
      chk("final_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_port_ctrl.md
# ram_port_ctrl

Single-port access controller placed directly upstream of the 256×16 `ram` block; it owns every RAM control pin. It accepts read/write requests over a valid/ready handshake, returns read data with a valid strobe, and provides a hardware fill sequencer that writes a constant to every word after reset or on command. Upstream masters never drive `ram` directly.

## Interface
Parameters:
- `AW`, 8, address width.
- `DW`, 16, data width.
- `DEPTH`, 256, words filled by init (`2**AW`).
- `RD_LAT`, 1, RAM read latency. A read data word is valid `RD_LAT` edges after the RAM samples `enable=1, write_en=0`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init_start`  in  1  one-cycle request to fill the RAM.
- `init_value`  in  DW  fill word; sampled with `init_start`.
- `init_busy`  out  1  high while a fill is running.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  request address.
- `req_wdata`  in  DW  write data.
- `rsp_valid`  out  1  `rsp_data` is valid for one cycle.
- `rsp_data`  out  DW  read result.
- `ram_addr`  out  AW  to `ram.addr`.
- `ram_data_in`  out  DW  to `ram.data_in`.
- `ram_enable`  out  1  to `ram.enable`.
- `ram_write_en`  out  1  to `ram.write_en`.
- `ram_data_out`  in  DW  from `ram.data_out`.

## Operation
- Reset values:
  - all outputs are 0;
  - state is IDLE;
  - fill counter is 0;
  - the response pipeline is empty.
- FSM states:
  - IDLE → INIT when `init_start` is 1.
  - INIT → IDLE after the write to address `DEPTH-1` is issued.
- `req_ready = (state==IDLE) && !init_start`. This is combinational. `init_start` wins over a simultaneous request.
- Acceptance occurs when `req_valid && req_ready` at a rising edge. On the next cycle the RAM ports are registered as follows:
  - `ram_enable=1`;
  - `ram_write_en=req_write`;
  - `ram_addr=req_addr`;
  - `ram_data_in=req_wdata`.
- `ram_enable=0` on any cycle without an issued operation. `ram_write_en` is then also 0.
- One request is accepted per cycle with no bubbles.
- Writes generate no response.
- Reads push a tag into a `RD_LAT+1`-deep valid shift register. When the tag exits, `rsp_data` registers `ram_data_out` and `rsp_valid` pulses.
- There is no response back-pressure.
- INIT behaviour:
  - `init_value` is latched on the start edge.
  - One write is issued per cycle to addresses 0,1,…,`DEPTH-1`.
  - The counter wraps to 0 on exit.
  - `init_start` during INIT is ignored.
- Reads already in flight when INIT begins complete normally, and their `rsp_valid` pulses still appear.
- Read-after-write to the same address in consecutive accepted requests returns the new data.
- Asserting `rst_n` low mid-fill or mid-read:
  - aborts immediately;
  - all outputs return to 0;
  - in-flight responses are discarded.

## Timing
- Request accepted at edge E. RAM pins show the operation during cycle E→E+1, and the RAM acts at E+1.
- Read latency is `RD_LAT+1` edges from acceptance. With `RD_LAT=1`, `rsp_valid` is high in cycle E+2→E+3.
- `init_start` sampled at edge S:
  - `init_busy` is high from S to S+`DEPTH`;
  - the address-k write is on the pins in cycle S+k→S+k+1;
  - `req_ready` rises in the cycle after the last fill write.
- Fill duration is exactly `DEPTH` cycles. No other combinational paths exist besides `req_ready`.

## Structure
- `ram_pkg`:
  - `AW`, `DW`, `DEPTH` defaults;
  - `typedef enum logic {IDLE, INIT} ram_ctrl_state_t`;
  - `typedef logic [AW-1:0] ram_addr_t`;
  - `typedef logic [DW-1:0] ram_word_t`.
- Sub-module `ram_rd_pipe`: the parameterised `RD_LAT+1` valid shift register with its output data register. Everything else is flat.

## Test plan
- Reset with `rst_n=0` for 3 cycles, then release → all outputs 0; `req_ready=1` on the first cycle after release.
- `init_start` with `init_value=16'hA5A5` → 256 consecutive writes to addr 0..255; `init_busy` high for 256 cycles; then read addr 0, 37, 255 → each returns `16'hA5A5` two cycles after acceptance.
- Write addr `i` = `i*2` for i=0..149, then read i=0..149 back-to-back → 150 consecutive `rsp_valid` pulses with data `i*2`, in order, with no gaps.
- Write addr 10 = `16'h1234` followed immediately by a read of addr 10 → response `16'h1234`.
- Issue 2 reads, then `init_start` on the next cycle while a request is also valid → both reads respond; the new request is not accepted until `init_busy` falls.
- Drop `rst_n` at fill address 100 → all outputs 0 immediately; the next `init_start` restarts from address 0.
